// File: rtl/game_controller.sv
// game_controller: turns button presses into cursor moves and step/flag
// actions on a ROWS x COLS board, producing the flag and step maps read by
// the gameboard renderer, plus win/loss status and a one-cycle redraw pulse.
//
// Optional build macro: CURSOR_WRAP_EN
//   defined   -> cursor wraps around the board edges
//   undefined -> cursor saturates at the board edges
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_PLAY  | normal play; moves, flags and steps are accepted
// ST_CHECK | one cycle after a safe step; decides win or back to play
// ST_LOST  | a mine was stepped on; only a step (restart) is accepted
// ST_WON   | every safe cell revealed; only a step (restart) is accepted

module game_controller #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [ROWS*COLS-1:0]     mineMap,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_step,
  input  logic                     btn_flag,
  output logic [ROWS*COLS-1:0]     flagMap,
  output logic [ROWS*COLS-1:0]     stepMap,
  output logic [$clog2(COLS)-1:0]  cursor_x,
  output logic [$clog2(ROWS)-1:0]  cursor_y,
  output logic                     game_over,
  output logic                     game_won,
  output logic                     changed
);

  localparam int N  = ROWS * COLS;
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int IW = $clog2(N);

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  // bit positions inside the packed button vector
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_STEP  = 4;
  localparam int B_FLAG  = 5;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOST  = 2'd2,
    ST_WON   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    flag_q, flag_d;
  logic [N-1:0]    step_q, step_d;
  logic [XW-1:0]   cx_q, cx_d;
  logic [YW-1:0]   cy_q, cy_d;
  logic            changed_q, changed_d;
  logic [5:0]      prev_q;
  logic [5:0]      btn_vec;
  logic [5:0]      rise;
  logic [IW-1:0]   cell_idx;

  assign btn_vec  = {btn_flag, btn_step, btn_right, btn_left, btn_down, btn_up};
  assign rise     = btn_vec & ~prev_q;
  assign cell_idx = IW'(cy_q) * IW'(COLS) + IW'(cx_q);

  // State, maps, cursor, redraw pulse and button history registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_PLAY;
      flag_q    <= '0;
      step_q    <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      changed_q <= 1'b0;
      prev_q    <= '0;
    end else begin
      state_q   <= state_d;
      flag_q    <= flag_d;
      step_q    <= step_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      changed_q <= changed_d;
      prev_q    <= btn_vec;
    end
  end

  // Next-state and datapath decode; one prioritised action per cycle.
  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    step_d    = step_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    changed_d = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (rise[B_STEP]) begin
          if (!(flag_q[cell_idx] || step_q[cell_idx])) begin
            changed_d = 1'b1;
            if (mineMap[cell_idx]) begin
              step_d  = step_q | mineMap;
              state_d = ST_LOST;
            end else begin
              step_d[cell_idx] = 1'b1;
              state_d          = ST_CHECK;
            end
          end
        end else if (rise[B_FLAG]) begin
          if (!step_q[cell_idx]) begin
            flag_d[cell_idx] = ~flag_q[cell_idx];
            changed_d        = 1'b1;
          end
        end else if (rise[B_UP]) begin
`ifdef CURSOR_WRAP_EN
          cy_d      = (cy_q == '0) ? Y_MAX : cy_q - Y_ONE;
          changed_d = 1'b1;
`else
          if (cy_q != '0) begin
            cy_d      = cy_q - Y_ONE;
            changed_d = 1'b1;
          end
`endif
        end else if (rise[B_DOWN]) begin
`ifdef CURSOR_WRAP_EN
          cy_d      = (cy_q == Y_MAX) ? '0 : cy_q + Y_ONE;
          changed_d = 1'b1;
`else
          if (cy_q != Y_MAX) begin
            cy_d      = cy_q + Y_ONE;
            changed_d = 1'b1;
          end
`endif
        end else if (rise[B_LEFT]) begin
`ifdef CURSOR_WRAP_EN
          cx_d      = (cx_q == '0) ? X_MAX : cx_q - X_ONE;
          changed_d = 1'b1;
`else
          if (cx_q != '0) begin
            cx_d      = cx_q - X_ONE;
            changed_d = 1'b1;
          end
`endif
        end else if (rise[B_RIGHT]) begin
`ifdef CURSOR_WRAP_EN
          cx_d      = (cx_q == X_MAX) ? '0 : cx_q + X_ONE;
          changed_d = 1'b1;
`else
          if (cx_q != X_MAX) begin
            cx_d      = cx_q + X_ONE;
            changed_d = 1'b1;
          end
`endif
        end
      end

      // Edges seen here are intentionally dropped; history still updates.
      ST_CHECK: begin
        state_d = (&(step_q | mineMap)) ? ST_WON : ST_PLAY;
      end

      ST_LOST, ST_WON: begin
        if (rise[B_STEP]) begin
          flag_d    = '0;
          step_d    = '0;
          cx_d      = '0;
          cy_d      = '0;
          state_d   = ST_PLAY;
          changed_d = 1'b1;
        end
      end

      default: state_d = ST_PLAY;
    endcase
  end

  assign flagMap   = flag_q;
  assign stepMap   = step_q;
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;
  assign changed   = changed_q;
  assign game_over = (state_q == ST_LOST);
  assign game_won  = (state_q == ST_WON);

endmodule
